// File: rtl/c1_slave_port.sv
// CPU bus-1 slave front end: decodes the two-beat A1/D1/C1 command, issues one request
// to the cache core, then drives C1 RESPONSE (and read data on D1) back to the CPU.
module c1_slave_port #(
  parameter int ADDR1_W  = 15,
  parameter int DATA1_W  = 16,
  parameter int CTR1_W   = 3,
  parameter int OFFSET_W = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR1_W-1:0]          a1,
  input  logic [DATA1_W-1:0]          d1_in,
  output logic [DATA1_W-1:0]          d1_out,
  output logic                        d1_oe,
  input  logic [CTR1_W-1:0]           c1_in,
  output logic [CTR1_W-1:0]           c1_out,
  output logic                        c1_oe,
  output logic                        req_valid,
  output logic [2:0]                  req_op,
  output logic [ADDR1_W+OFFSET_W-1:0] req_addr,
  output logic [31:0]                 req_wdata,
  input  logic                        req_ready,
  input  logic                        rsp_valid,
  input  logic [31:0]                 rsp_rdata,
  output logic                        proto_err
);

  localparam int ADDR_W = ADDR1_W + OFFSET_W;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_RD8      = 3'd1;
  localparam logic [2:0] OP_RD16     = 3'd2;
  localparam logic [2:0] OP_RD32     = 3'd3;
  localparam logic [2:0] OP_INV      = 3'd4;
  localparam logic [2:0] OP_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_ISSUE,
    S_WAIT,
    S_RESP1,
    S_RESP2,
    S_TURN
  } state_t;

  state_t              state_reg;
  logic [2:0]          op_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         rdata_reg;
  logic                req_valid_reg;
  logic [DATA1_W-1:0]  d1_out_reg;
  logic                d1_oe_reg;
  logic [CTR1_W-1:0]   c1_out_reg;
  logic                c1_oe_reg;
  logic                proto_err_reg;

  logic                cmd_seen;
  logic                op_is_read;
  logic [DATA1_W-1:0]  rsp_lo_beat;

  // Only fully known opcodes count as commands; X/Z on a floating C1 falls to default.
  always_comb begin
    cmd_seen = 1'b0;
    case (c1_in)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: cmd_seen = 1'b1;
      default:                                  cmd_seen = 1'b0;
    endcase
  end

  assign op_is_read = (op_reg == OP_RD8) || (op_reg == OP_RD16) || (op_reg == OP_RD32);

  // First read beat, byte by byte: RD8 returns only byte 0, upper bytes forced to zero.
  for (genvar gi = 0; gi < DATA1_W / 8; gi++) begin : g_lo_byte
    if (gi == 0) begin : g_byte0
      assign rsp_lo_beat[7:0] = rsp_rdata[7:0];
    end else begin : g_byte_hi
      assign rsp_lo_beat[8*gi +: 8] = (op_reg == OP_RD8) ? 8'h00 : rsp_rdata[8*gi +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_NOP;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      req_valid_reg <= 1'b0;
      d1_out_reg    <= '0;
      d1_oe_reg     <= 1'b0;
      c1_out_reg    <= '0;
      c1_oe_reg     <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      // A command outside IDLE or a response outside WAIT is flagged and otherwise ignored.
      proto_err_reg <= (cmd_seen && (state_reg != S_IDLE)) ||
                       (rsp_valid && (state_reg != S_WAIT));

      case (state_reg)
        S_IDLE: begin
          if (cmd_seen) begin
            op_reg                     <= c1_in;
            addr_reg[ADDR_W-1:OFFSET_W] <= a1;
            wdata_reg[15:0]            <= d1_in;
            if (c1_in == OP_INV) begin
              addr_reg[OFFSET_W-1:0] <= '0;
              wdata_reg[31:16]       <= '0;
              req_valid_reg          <= 1'b1;
              state_reg              <= S_ISSUE;
            end else begin
              state_reg <= S_ADDR2;
            end
          end
        end

        S_ADDR2: begin
          addr_reg[OFFSET_W-1:0] <= a1[OFFSET_W-1:0];
          wdata_reg[31:16]       <= d1_in;
          req_valid_reg          <= 1'b1;
          state_reg              <= S_ISSUE;
        end

        S_ISSUE: begin
          if (req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rsp_valid) begin
            rdata_reg  <= rsp_rdata;
            c1_oe_reg  <= 1'b1;
            c1_out_reg <= OP_RESPONSE;
            d1_oe_reg  <= op_is_read;
            d1_out_reg <= op_is_read ? rsp_lo_beat : '0;
            state_reg  <= S_RESP1;
          end
        end

        S_RESP1: begin
          if (op_reg == OP_RD32) begin
            d1_out_reg <= rdata_reg[31:16];
            state_reg  <= S_RESP2;
          end else begin
            c1_oe_reg  <= 1'b0;
            c1_out_reg <= '0;
            d1_oe_reg  <= 1'b0;
            d1_out_reg <= '0;
            state_reg  <= S_TURN;
          end
        end

        S_RESP2: begin
          c1_oe_reg  <= 1'b0;
          c1_out_reg <= '0;
          d1_oe_reg  <= 1'b0;
          d1_out_reg <= '0;
          state_reg  <= S_TURN;
        end

        S_TURN: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req_valid = req_valid_reg;
  assign req_op    = op_reg;
  assign req_addr  = addr_reg;
  assign req_wdata = wdata_reg;
  assign d1_out    = d1_out_reg;
  assign d1_oe     = d1_oe_reg;
  assign c1_out    = c1_out_reg;
  assign c1_oe     = c1_oe_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_c1_slave_port.sv
// Directed bench for c1_slave_port: hand-computed bus transactions checked cycle by cycle.
module tb_c1_slave_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] a1;
  logic [15:0] d1_in;
  logic [15:0] d1_out;
  logic        d1_oe;
  logic [2:0]  c1_in;
  logic [2:0]  c1_out;
  logic        c1_oe;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  c1_slave_port dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a1        (a1),
    .d1_in     (d1_in),
    .d1_out    (d1_out),
    .d1_oe     (d1_oe),
    .c1_in     (c1_in),
    .c1_out    (c1_out),
    .c1_oe     (c1_oe),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-beat command: beat 1 (op, tag_set, low data), beat 2 (c1 value, offset, high data).
  task automatic cmd2(input logic [2:0] op, input logic [14:0] a, input logic [15:0] dlo,
                      input logic [3:0] off, input logic [15:0] dhi, input logic [2:0] c2);
    c1_in = op; a1 = a; d1_in = dlo;
    tick();
    c1_in = c2; a1 = {11'h0, off}; d1_in = dhi;
    tick();
    c1_in = 3'd0; a1 = '0; d1_in = '0;
  endtask

  task automatic handshake();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    rsp_valid = 1'b1; rsp_rdata = data;
    tick();
    rsp_valid = 1'b0; rsp_rdata = '0;
  endtask

  initial begin
    reset_n = 1'b0; a1 = '0; d1_in = '0; c1_in = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    tick(); tick();
    check("rst_c1_oe", c1_oe, 0);
    check("rst_d1_oe", d1_oe, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_proto_err", proto_err, 0);
    reset_n = 1'b1;
    tick();

    // RD8: earliest RESPONSE three edges after the command beat
    cmd2(3'd1, 15'h1A2B, 16'h0000, 4'h5, 16'h0000, 3'd0);
    check("rd8_req_valid", req_valid, 1);
    check("rd8_req_addr", req_addr, 19'h1A2B5);
    check("rd8_req_op", req_op, 1);
    handshake();
    check("rd8_req_drop", req_valid, 0);
    respond(32'h0000ABC3);
    check("rd8_c1_oe", c1_oe, 1);
    check("rd8_c1_out", c1_out, 7);
    check("rd8_d1_oe", d1_oe, 1);
    check("rd8_d1_out", d1_out, 16'h00C3);
    tick();
    check("rd8_turn_c1_oe", c1_oe, 0);
    check("rd8_turn_d1_oe", d1_oe, 0);
    tick();
    $display("txn rd8 addr=1a2b5 done");

    // WR32: data assembled from two halves, no D1 drive during RESPONSE
    cmd2(3'd7, 15'h0010, 16'hBEEF, 4'h4, 16'hDEAD, 3'd0);
    check("wr32_wdata", req_wdata, 32'hDEADBEEF);
    check("wr32_op", req_op, 7);
    check("wr32_addr", req_addr, 19'h00104);
    handshake();
    respond(32'h0);
    check("wr32_c1_oe", c1_oe, 1);
    check("wr32_c1_out", c1_out, 7);
    check("wr32_d1_oe", d1_oe, 0);
    tick();
    check("wr32_turn_c1_oe", c1_oe, 0);
    tick();
    $display("txn wr32 data=deadbeef done");

    // RD32: two RESPONSE beats, low half first, then one turnaround cycle
    cmd2(3'd3, 15'h0100, 16'h0, 4'h0, 16'h0, 3'd0);
    handshake();
    respond(32'h12345678);
    check("rd32_beat1_d1", d1_out, 16'h5678);
    check("rd32_beat1_oe", d1_oe, 1);
    tick();
    check("rd32_beat2_d1", d1_out, 16'h1234);
    check("rd32_beat2_c1", c1_out, 7);
    check("rd32_beat2_c1_oe", c1_oe, 1);
    tick();
    check("rd32_turn_c1_oe", c1_oe, 0);
    check("rd32_turn_d1_oe", d1_oe, 0);
    tick();
    $display("txn rd32 data=12345678 done");

    // RD16 with req_ready held low for five cycles
    cmd2(3'd2, 15'h7FFF, 16'h0, 4'hF, 16'h0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), req_valid, 1);
      check($sformatf("stall_addr_%0d", i), req_addr, 19'h7FFFF);
    end
    req_ready = 1'b1;
    tick();
    check("stall_accept", req_valid, 0);
    tick();
    check("stall_single_hs", req_valid, 0);
    req_ready = 1'b0;
    respond(32'h0000BEEF);
    check("stall_d1_out", d1_out, 16'hBEEF);
    tick(); tick();
    $display("txn rd16 stalled addr=7ffff done");

    // INV: single-phase command, RESPONSE two edges after the beat
    c1_in = 3'd4; a1 = 15'h2222;
    tick();
    c1_in = 3'd0; a1 = '0;
    check("inv_valid", req_valid, 1);
    check("inv_addr", req_addr, 19'h22220);
    check("inv_op", req_op, 4);
    handshake();
    respond(32'hFFFFFFFF);
    check("inv_c1_oe", c1_oe, 1);
    check("inv_d1_oe", d1_oe, 0);
    tick(); tick();
    $display("txn inv addr=22220 done");

    // Protocol errors: command during WAIT, then rsp_valid while IDLE
    cmd2(3'd2, 15'h0040, 16'h0, 4'h2, 16'h0, 3'd0);
    handshake();
    c1_in = 3'd2;
    tick();
    c1_in = 3'd0;
    check("perr_wait_cmd", proto_err, 1);
    tick();
    check("perr_wait_pulse", proto_err, 0);
    check("perr_wait_valid", req_valid, 0);
    respond(32'h0000CAFE);
    check("perr_wait_c1_oe", c1_oe, 1);
    check("perr_wait_d1", d1_out, 16'hCAFE);
    tick(); tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
    tick();
    rsp_valid = 1'b0;
    check("perr_idle_rsp", proto_err, 1);
    check("perr_idle_c1_oe", c1_oe, 0);
    tick();
    check("perr_idle_pulse", proto_err, 0);
    $display("txn proto_err wait/idle done");

    // Non-NOP on the second beat: flagged, latched opcode kept
    cmd2(3'd2, 15'h0003, 16'h0, 4'h6, 16'h0, 3'd5);
    check("perr_addr2", proto_err, 1);
    check("perr_addr2_op", req_op, 2);
    check("perr_addr2_addr", req_addr, 19'h00036);
    handshake();
    respond(32'h0000A5A5);
    check("perr_addr2_d1", d1_out, 16'hA5A5);
    tick(); tick();
    $display("txn proto_err addr2 done");

    // Reset during RESP2, then a fresh RD8
    cmd2(3'd3, 15'h0200, 16'h0, 4'h0, 16'h0, 3'd0);
    handshake();
    respond(32'hAAAA5555);
    tick();
    check("rst2_in_resp2", c1_oe, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst2_c1_oe", c1_oe, 0);
    check("rst2_d1_oe", d1_oe, 0);
    check("rst2_req_valid", req_valid, 0);
    cmd2(3'd1, 15'h0001, 16'h0, 4'h2, 16'h0, 3'd0);
    check("rst2_rd8_addr", req_addr, 19'h00012);
    handshake();
    respond(32'h00001234);
    check("rst2_rd8_d1", d1_out, 16'h0034);
    check("rst2_rd8_c1", c1_out, 7);
    tick(); tick();
    $display("txn reset-in-resp2 then rd8 done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
